// File: rtl/bp_be_rpt_assoc_pkg.sv
// Shared types for the reference prediction table and its prefetch generator.
// Holds the default address width and the state encodings of both FSMs.
package bp_be_rpt_assoc_pkg;

   localparam int rpt_vaddr_width_gp = 39;

   typedef enum logic [1:0] {
      e_reset,
      e_clear,
      e_run
   } rpt_state_e;

   typedef enum logic {
      e_idle,
      e_issue
   } pf_state_e;

endpackage

// File: rtl/bp_be_rpt_assoc_pf_gen.sv
// Prefetch stream generator: latches base/stride on a confirm and walks
// base + k*stride for k = 1..pf_degree_p over a valid/ready handshake.
//
// state   | meaning
// e_idle  | no stream active; a confirm starts a new one
// e_issue | presenting pf_addr_o; later confirms are dropped
module bp_be_rpt_assoc_pf_gen
   import bp_be_rpt_assoc_pkg::*;
 #(parameter int vaddr_width_p  = rpt_vaddr_width_gp
   , parameter int stride_width_p = 12
   , parameter int pf_degree_p    = 2
   )
  (input  logic                      clk_i
   , input  logic                      reset_i
   , input  logic                      flush_i
   , input  logic                      cfm_v_i
   , input  logic [vaddr_width_p-1:0]  base_i
   , input  logic [stride_width_p-1:0] stride_i
   , output logic                      pf_v_o
   , input  logic                      pf_ready_i
   , output logic [vaddr_width_p-1:0]  pf_addr_o
   );

   localparam int cnt_w_lp = (pf_degree_p > 1) ? $clog2(pf_degree_p) : 1;

   pf_state_e                state_q, state_d;
   logic [vaddr_width_p-1:0] addr_q, addr_d;
   logic [vaddr_width_p-1:0] stride_q, stride_d;
   logic [cnt_w_lp-1:0]      cnt_q, cnt_d;

   logic [vaddr_width_p-1:0] stride_sext;
   logic                     hs, last_hs, load;

   assign stride_sext = {{(vaddr_width_p-stride_width_p){stride_i[stride_width_p-1]}}, stride_i};

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      stride_d = stride_q;
      cnt_d    = cnt_q;
      hs       = (state_q == e_issue) && pf_ready_i;
      last_hs  = hs && (cnt_q == '0);
      // the final handshake frees the generator, so a confirm in that cycle is taken
      load     = cfm_v_i && ((state_q == e_idle) || last_hs);
      if (flush_i) begin
         state_d = e_idle;
      end else if (load) begin
         state_d  = e_issue;
         addr_d   = base_i + stride_sext;
         stride_d = stride_sext;
         cnt_d    = cnt_w_lp'(pf_degree_p - 1);
      end else if (hs) begin
         if (cnt_q == '0) begin
            state_d = e_idle;
         end else begin
            addr_d = addr_q + stride_q;
            cnt_d  = cnt_q - cnt_w_lp'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= e_idle;
         addr_q   <= '0;
         stride_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         stride_q <= stride_d;
         cnt_q    <= cnt_d;
      end
   end

   assign pf_v_o    = (state_q == e_issue);
   assign pf_addr_o = addr_q;

endmodule

// File: rtl/bp_be_rpt_assoc.sv
// Set-associative reference prediction table for committed loads: tracks
// per-PC last address, stride and confidence, and feeds a prefetch stream.
//
// state   | meaning
// e_reset | entered on reset, table contents unknown
// e_clear | zeroing one set per cycle, loads not accepted
// e_run   | accepting loads, one per cycle
module bp_be_rpt_assoc
   import bp_be_rpt_assoc_pkg::*;
 #(parameter int vaddr_width_p    = rpt_vaddr_width_gp
   , parameter int sets_p           = 32
   , parameter int ways_p           = 2
   , parameter int stride_width_p   = 12
   , parameter int ctr_width_p      = 2
   , parameter int confirm_thresh_p = 2
   , parameter int pf_degree_p      = 2
   )
  (input  logic                      clk_i
   , input  logic                      reset_i
   , input  logic                      flush_i
   , output logic                      ready_o
   , input  logic                      v_i
   , input  logic [vaddr_width_p-1:0]  pc_i
   , input  logic [vaddr_width_p-1:0]  eff_addr_i
   , output logic                      confirm_v_o
   , output logic [vaddr_width_p-1:0]  confirm_pc_o
   , output logic [stride_width_p-1:0] stride_o
   , output logic                      pf_v_o
   , input  logic                      pf_ready_i
   , output logic [vaddr_width_p-1:0]  pf_addr_o
   );

   localparam int idx_w_lp  = $clog2(sets_p);
   localparam int way_w_lp  = (ways_p > 1) ? $clog2(ways_p) : 1;
   localparam int tag_w_lp  = vaddr_width_p - idx_w_lp;
   localparam int hi_w_lp   = vaddr_width_p - stride_width_p + 1;

   rpt_state_e          state_q, state_d;
   logic [idx_w_lp-1:0] clr_idx_q, clr_idx_d;

   logic [ways_p-1:0]                     mem_v_q    [sets_p];
   logic [ways_p-1:0][tag_w_lp-1:0]       mem_tag_q  [sets_p];
   logic [ways_p-1:0][vaddr_width_p-1:0]  mem_last_q [sets_p];
   logic [ways_p-1:0][stride_width_p-1:0] mem_str_q  [sets_p];
   logic [ways_p-1:0][ctr_width_p-1:0]    mem_ctr_q  [sets_p];
   logic [way_w_lp-1:0]                   mem_vict_q [sets_p];

   logic [ways_p-1:0]                     rd_v_q, rd_v_d, wr_v, mem_wv;
   logic [ways_p-1:0][tag_w_lp-1:0]       rd_tag_q, rd_tag_d, wr_tag, mem_wtag;
   logic [ways_p-1:0][vaddr_width_p-1:0]  rd_last_q, rd_last_d, wr_last, mem_wlast;
   logic [ways_p-1:0][stride_width_p-1:0] rd_str_q, rd_str_d, wr_str, mem_wstr;
   logic [ways_p-1:0][ctr_width_p-1:0]    rd_ctr_q, rd_ctr_d, wr_ctr, mem_wctr;
   logic [way_w_lp-1:0]                   rd_vict_q, rd_vict_d, wr_vict, mem_wvict;

   logic                      mem_we;
   logic [idx_w_lp-1:0]       mem_widx;

   logic                      s1_v_q, s1_v_d;
   logic [vaddr_width_p-1:0]  s1_pc_q, s1_pc_d, s1_addr_q, s1_addr_d;
   logic [idx_w_lp-1:0]       s1_idx, in_idx;
   logic [tag_w_lp-1:0]       s1_tag;

   logic                      hit, inv_found, diff_fits, str_match, s1_cfm, bypass, accept;
   logic [way_w_lp-1:0]       hit_way, inv_way, upd_way;
   logic [vaddr_width_p-1:0]  sel_last, diff;
   logic [hi_w_lp-1:0]        diff_hi;
   logic [stride_width_p-1:0] sel_str, new_str;
   logic [ctr_width_p-1:0]    sel_ctr, new_ctr;

   logic                      cfm_v_q, cfm_v_d;
   logic [vaddr_width_p-1:0]  cfm_pc_q, cfm_pc_d;
   logic [stride_width_p-1:0] cfm_str_q, cfm_str_d;

   assign ready_o = (state_q == e_run);
   assign accept  = v_i && ready_o && !flush_i;
   assign in_idx  = pc_i[idx_w_lp-1:0];
   assign s1_idx  = s1_pc_q[idx_w_lp-1:0];
   assign s1_tag  = s1_pc_q[vaddr_width_p-1:idx_w_lp];

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      case (state_q)
         e_reset: begin
            state_d   = e_clear;
            clr_idx_d = '0;
         end
         e_clear: begin
            if (flush_i) begin
               clr_idx_d = '0;
            end else if (clr_idx_q == idx_w_lp'(sets_p - 1)) begin
               state_d = e_run;
            end else begin
               clr_idx_d = clr_idx_q + idx_w_lp'(1);
            end
         end
         e_run: begin
            if (flush_i) begin
               state_d   = e_clear;
               clr_idx_d = '0;
            end
         end
         default: state_d = e_reset;
      endcase
   end

   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      // descending scan so the lowest-index invalid way wins
      for (int w = ways_p - 1; w >= 0; w--) begin
         if (rd_v_q[w] && (rd_tag_q[w] == s1_tag)) begin
            hit     = 1'b1;
            hit_way = way_w_lp'(w);
         end
         if (!rd_v_q[w]) begin
            inv_found = 1'b1;
            inv_way   = way_w_lp'(w);
         end
      end
      sel_last  = rd_last_q[hit_way];
      sel_str   = rd_str_q[hit_way];
      sel_ctr   = rd_ctr_q[hit_way];
      diff      = s1_addr_q - sel_last;
      diff_hi   = diff[vaddr_width_p-1:stride_width_p-1];
      diff_fits = (&diff_hi) || !(|diff_hi);
      str_match = diff_fits && (diff[stride_width_p-1:0] == sel_str);
      new_str   = '0;
      new_ctr   = '0;
      if (hit) begin
         if (str_match) begin
            new_str = sel_str;
            new_ctr = (&sel_ctr) ? sel_ctr : sel_ctr + ctr_width_p'(1);
         end else begin
            new_str = diff_fits ? diff[stride_width_p-1:0] : '0;
         end
      end
      upd_way  = hit ? hit_way : (inv_found ? inv_way : rd_vict_q);
      wr_v     = rd_v_q;
      wr_tag   = rd_tag_q;
      wr_last  = rd_last_q;
      wr_str   = rd_str_q;
      wr_ctr   = rd_ctr_q;
      wr_v[upd_way]    = 1'b1;
      wr_tag[upd_way]  = s1_tag;
      wr_last[upd_way] = s1_addr_q;
      wr_str[upd_way]  = new_str;
      wr_ctr[upd_way]  = new_ctr;
      wr_vict  = rd_vict_q;
      if (!hit && !inv_found) begin
         wr_vict = (rd_vict_q == way_w_lp'(ways_p - 1)) ? '0 : rd_vict_q + way_w_lp'(1);
      end
      s1_cfm = s1_v_q && hit && (new_ctr >= ctr_width_p'(confirm_thresh_p)) && (new_str != '0);
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_widx  = s1_idx;
      mem_wv    = wr_v;
      mem_wtag  = wr_tag;
      mem_wlast = wr_last;
      mem_wstr  = wr_str;
      mem_wctr  = wr_ctr;
      mem_wvict = wr_vict;
      if (state_q == e_clear) begin
         mem_we    = 1'b1;
         mem_widx  = clr_idx_q;
         mem_wv    = '0;
         mem_wtag  = '0;
         mem_wlast = '0;
         mem_wstr  = '0;
         mem_wctr  = '0;
         mem_wvict = '0;
      end else if (s1_v_q) begin
         mem_we = 1'b1;
      end
   end

   // a back-to-back load to the same set must see the row being written now
   always_comb begin
      bypass    = s1_v_q && (s1_idx == in_idx);
      rd_v_d    = bypass ? wr_v    : mem_v_q[in_idx];
      rd_tag_d  = bypass ? wr_tag  : mem_tag_q[in_idx];
      rd_last_d = bypass ? wr_last : mem_last_q[in_idx];
      rd_str_d  = bypass ? wr_str  : mem_str_q[in_idx];
      rd_ctr_d  = bypass ? wr_ctr  : mem_ctr_q[in_idx];
      rd_vict_d = bypass ? wr_vict : mem_vict_q[in_idx];
      s1_v_d    = accept;
      s1_pc_d   = pc_i;
      s1_addr_d = eff_addr_i;
      cfm_v_d   = s1_cfm && !flush_i;
      cfm_pc_d  = cfm_v_d ? s1_pc_q : cfm_pc_q;
      cfm_str_d = cfm_v_d ? new_str : cfm_str_q;
   end

   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         mem_v_q[mem_widx]    <= mem_wv;
         mem_tag_q[mem_widx]  <= mem_wtag;
         mem_last_q[mem_widx] <= mem_wlast;
         mem_str_q[mem_widx]  <= mem_wstr;
         mem_ctr_q[mem_widx]  <= mem_wctr;
         mem_vict_q[mem_widx] <= mem_wvict;
      end
      rd_v_q    <= rd_v_d;
      rd_tag_q  <= rd_tag_d;
      rd_last_q <= rd_last_d;
      rd_str_q  <= rd_str_d;
      rd_ctr_q  <= rd_ctr_d;
      rd_vict_q <= rd_vict_d;
      s1_pc_q   <= s1_pc_d;
      s1_addr_q <= s1_addr_d;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= e_reset;
         clr_idx_q <= '0;
         s1_v_q    <= 1'b0;
         cfm_v_q   <= 1'b0;
         cfm_pc_q  <= '0;
         cfm_str_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
         s1_v_q    <= s1_v_d;
         cfm_v_q   <= cfm_v_d;
         cfm_pc_q  <= cfm_pc_d;
         cfm_str_q <= cfm_str_d;
      end
   end

   assign confirm_v_o  = cfm_v_q;
   assign confirm_pc_o = cfm_pc_q;
   assign stride_o     = cfm_str_q;

   bp_be_rpt_assoc_pf_gen
    #(.vaddr_width_p(vaddr_width_p)
      ,.stride_width_p(stride_width_p)
      ,.pf_degree_p(pf_degree_p)
      )
    pf_gen
     (.clk_i(clk_i)
      ,.reset_i(reset_i)
      ,.flush_i(flush_i)
      ,.cfm_v_i(cfm_v_d)
      ,.base_i(s1_addr_q)
      ,.stride_i(new_str)
      ,.pf_v_o(pf_v_o)
      ,.pf_ready_i(pf_ready_i)
      ,.pf_addr_o(pf_addr_o)
      );

endmodule

// File: tb/tb_bp_be_rpt_assoc.sv
// Directed bench for bp_be_rpt_assoc: training, eviction, bypass,
// prefetch backpressure and flush, all checked against hand-computed values.
module tb_bp_be_rpt_assoc;

   localparam int va_lp = 39;

   logic             clk = 1'b0;
   logic             reset_i, flush_i, v_i, pf_ready_i;
   logic [va_lp-1:0] pc_i, eff_addr_i;
   logic             ready_o, confirm_v_o, pf_v_o;
   logic [va_lp-1:0] confirm_pc_o, pf_addr_o;
   logic [11:0]      stride_o;

   always #5 clk = ~clk;

   bp_be_rpt_assoc
    #(.vaddr_width_p(va_lp), .sets_p(32), .ways_p(2), .stride_width_p(12)
      ,.ctr_width_p(2), .confirm_thresh_p(2), .pf_degree_p(2))
    dut
     (.clk_i(clk), .reset_i(reset_i), .flush_i(flush_i), .ready_o(ready_o)
      ,.v_i(v_i), .pc_i(pc_i), .eff_addr_i(eff_addr_i)
      ,.confirm_v_o(confirm_v_o), .confirm_pc_o(confirm_pc_o), .stride_o(stride_o)
      ,.pf_v_o(pf_v_o), .pf_ready_i(pf_ready_i), .pf_addr_o(pf_addr_o));

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int cfm_cnt = 0;
   int cfm_cyc = 0;
   logic [va_lp-1:0] cfm_pc;
   logic [11:0]      cfm_str;
   logic [va_lp-1:0] pf_q[$];

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // observe outputs half a cycle after the active edge
   always begin
      @(negedge clk);
      #1;
      if (confirm_v_o) begin
         cfm_cnt++;
         cfm_pc  = confirm_pc_o;
         cfm_str = stride_o;
         cfm_cyc = cyc;
      end
      if (pf_v_o && pf_ready_i) pf_q.push_back(pf_addr_o);
   end

   task automatic do_load(input logic [va_lp-1:0] pc, input logic [va_lp-1:0] addr);
      @(negedge clk);
      v_i = 1'b1; pc_i = pc; eff_addr_i = addr;
      @(negedge clk);
      v_i = 1'b0;
      acc_cyc = cyc;
   endtask

   task automatic load_chk(input string tag, input logic [va_lp-1:0] pc,
                           input logic [va_lp-1:0] addr, input int exp_cfm);
      int c0;
      c0 = cfm_cnt;
      do_load(pc, addr);
      repeat (3) @(negedge clk);
      #2;
      chk(tag, cfm_cnt - c0, exp_cfm);
   endtask

   task automatic chk_pf2(input string tag, input logic [va_lp-1:0] a0, input logic [va_lp-1:0] a1);
      logic [va_lp-1:0] g0, g1;
      g0 = (pf_q.size() > 0) ? pf_q[0] : '1;
      g1 = (pf_q.size() > 1) ? pf_q[1] : '1;
      chk({tag, "_n"}, pf_q.size(), 2);
      chk({tag, "_0"}, g0, a0);
      chk({tag, "_1"}, g1, a1);
   endtask

   task automatic sweep_len(output int n);
      n = 1;
      while (n < 100) begin
         @(posedge clk);
         @(negedge clk);
         if (ready_o) break;
         n++;
      end
   endtask

   initial begin
      int n, bad, c0;
      reset_i = 1'b1; flush_i = 1'b0; v_i = 1'b0; pc_i = '0; eff_addr_i = '0; pf_ready_i = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ready", ready_o, 0);
      chk("rst_outs", {confirm_v_o, pf_v_o, |confirm_pc_o, |stride_o, |pf_addr_o}, 0);
      reset_i = 1'b0;
      n = 0; bad = 0;
      while (n < 100) begin
         @(posedge clk);
         @(negedge clk);
         if (ready_o) break;
         n++;
         if (confirm_v_o || pf_v_o || (|confirm_pc_o) || (|stride_o) || (|pf_addr_o)) bad++;
      end
      chk("rst_sweep_len", n, 32);
      chk("rst_sweep_outs", bad, 0);

      // positive stride
      pf_q.delete();
      load_chk("t1_l0", 39'h1000, 39'h100, 0);
      load_chk("t1_l1", 39'h1000, 39'h108, 0);
      load_chk("t1_l2", 39'h1000, 39'h110, 0);
      load_chk("t1_l3", 39'h1000, 39'h118, 1);
      chk("t1_lat", cfm_cyc - acc_cyc, 1);
      chk("t1_pc", cfm_pc, 39'h1000);
      chk("t1_stride", cfm_str, 12'h008);
      chk_pf2("t1_pf", 39'h120, 39'h128);

      // negative stride
      pf_q.delete();
      load_chk("t2_l0", 39'h2004, 39'h200, 0);
      load_chk("t2_l1", 39'h2004, 39'h1F0, 0);
      load_chk("t2_l2", 39'h2004, 39'h1E0, 0);
      load_chk("t2_l3", 39'h2004, 39'h1D0, 1);
      chk("t2_stride", cfm_str, 12'hFF0);
      chk_pf2("t2_pf", 39'h1C0, 39'h1B0);

      // eviction within set 0, then retraining of 0x1000
      load_chk("t3_a", 39'h1080, 39'h700, 0);
      load_chk("t3_b", 39'h1100, 39'h800, 0);
      load_chk("t3_evicted", 39'h1000, 39'h120, 0);
      load_chk("t3_r1", 39'h1000, 39'h128, 0);
      load_chk("t3_r2", 39'h1000, 39'h130, 0);
      load_chk("t3_r3", 39'h1000, 39'h138, 1);
      chk("t3_pc", cfm_pc, 39'h1000);

      // back-to-back loads to one set exercise the read bypass
      repeat (3) @(negedge clk);
      #2;
      pf_q.delete();
      c0 = cfm_cnt;
      @(negedge clk); v_i = 1'b1; pc_i = 39'h2008; eff_addr_i = 39'h400;
      @(negedge clk); eff_addr_i = 39'h3F0;
      @(negedge clk); eff_addr_i = 39'h3E0;
      @(negedge clk); eff_addr_i = 39'h3D0;
      @(negedge clk); v_i = 1'b0;
      repeat (4) @(negedge clk);
      #2;
      chk("t4_cfm", cfm_cnt - c0, 1);
      chk("t4_pc", cfm_pc, 39'h2008);
      chk("t4_stride", cfm_str, 12'hFF0);
      chk_pf2("t4_pf", 39'h3C0, 39'h3B0);

      // prefetch backpressure, dropped confirm, flush mid-stream
      @(negedge clk); pf_ready_i = 1'b0;
      load_chk("t5_l0", 39'h300C, 39'h100, 0);
      load_chk("t5_l1", 39'h300C, 39'h108, 0);
      load_chk("t5_l2", 39'h300C, 39'h110, 0);
      load_chk("t5_l3", 39'h300C, 39'h118, 1);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (!pf_v_o || (pf_addr_o != 39'h120)) bad++;
      end
      chk("t5_hold", bad, 0);
      load_chk("t5_drop_cfm", 39'h2004, 39'h1C0, 1);
      chk("t5_drop_pc", cfm_pc, 39'h2004);
      chk("t5_held_v", pf_v_o, 1);
      chk("t5_held_addr", pf_addr_o, 39'h120);
      @(negedge clk); pf_ready_i = 1'b1;
      @(negedge clk); pf_ready_i = 1'b0;
      chk("t5_next_addr", pf_addr_o, 39'h128);
      flush_i = 1'b1;
      @(negedge clk); flush_i = 1'b0;
      chk("t5_flush_pfv", pf_v_o, 0);
      chk("t5_flush_rdy", ready_o, 0);
      sweep_len(n);
      chk("t5_sweep_len", n, 32);
      pf_ready_i = 1'b1;
      load_chk("t6_invalidated", 39'h2004, 39'h1B0, 0);
      chk("t6_pfv", pf_v_o, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
